// File: rtl/ms_wdt_window.sv
// Windowed watchdog: prescaled down-counter with early-kick detection,
// a sticky warn IRQ on first timeout and a held reset pulse on the second.
module ms_wdt_window #(
  parameter int WIDTH    = 32,
  parameter int PRE_W    = 8,
  parameter int RST_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] load,
  input  logic [WIDTH-1:0] window,
  input  logic [PRE_W-1:0] presc,
  input  logic             kick,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             irq,
  output logic             early_err,
  output logic             wdt_rst,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WARN = 2'd2,
    ST_BITE = 2'd3
  } state_t;

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  state_t           cur_state, nxt_state;
  logic [WIDTH-1:0] count_nxt;
  logic [PRE_W-1:0] pre_cnt, pre_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic             irq_nxt, early_nxt, wdt_rst_nxt;
  logic             tick;

  assign tick  = (pre_cnt == presc);
  assign state = cur_state;

  // State and all output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_IDLE;
      count     <= '0;
      pre_cnt   <= '0;
      hold_cnt  <= '0;
      irq       <= 1'b0;
      early_err <= 1'b0;
      wdt_rst   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      count     <= count_nxt;
      pre_cnt   <= pre_nxt;
      hold_cnt  <= hold_nxt;
      irq       <= irq_nxt;
      early_err <= early_nxt;
      wdt_rst   <= wdt_rst_nxt;
    end
  end

  // Next-state logic; later assignments to a flag override irq_clr so a set wins
  always_comb begin
    nxt_state   = cur_state;
    count_nxt   = count;
    pre_nxt     = pre_cnt;
    hold_nxt    = hold_cnt;
    irq_nxt     = irq;
    early_nxt   = early_err;
    wdt_rst_nxt = wdt_rst;

    if (irq_clr) begin
      irq_nxt   = 1'b0;
      early_nxt = 1'b0;
    end else begin
      irq_nxt   = irq;
    end

    case (cur_state)
      ST_IDLE: begin
        count_nxt = load;
        pre_nxt   = '0;
        if (en) begin
          nxt_state = ST_RUN;
        end else begin
          nxt_state = ST_IDLE;
        end
      end

      ST_RUN, ST_WARN: begin
        if (kick) begin
          if (count <= window) begin
            count_nxt = load;
            pre_nxt   = '0;
            irq_nxt   = 1'b0;
            nxt_state = ST_RUN;
          end else begin
            early_nxt   = 1'b1;
            wdt_rst_nxt = 1'b1;
            hold_nxt    = HOLD_LAST;
            nxt_state   = ST_BITE;
          end
        end else if (!en) begin
          nxt_state = ST_IDLE;
        end else if (tick) begin
          pre_nxt = '0;
          // Zero is tested before decrementing, so the counter never wraps
          if (count != '0) begin
            count_nxt = count - WIDTH'(1);
          end else if (cur_state == ST_RUN) begin
            irq_nxt   = 1'b1;
            count_nxt = load;
            nxt_state = ST_WARN;
          end else begin
            wdt_rst_nxt = 1'b1;
            hold_nxt    = HOLD_LAST;
            nxt_state   = ST_BITE;
          end
        end else begin
          pre_nxt = pre_cnt + PRE_W'(1);
        end
      end

      ST_BITE: begin
        if (hold_cnt == '0) begin
          wdt_rst_nxt = 1'b0;
          irq_nxt     = 1'b0;
          count_nxt   = load;
          pre_nxt     = '0;
          nxt_state   = en ? ST_RUN : ST_IDLE;
        end else begin
          hold_nxt = hold_cnt - HW'(1);
        end
      end

      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ms_wdt_window.sv
// Directed bench for ms_wdt_window: a vector table for the basic flow and
// short hand-written sequences for prescaler, window and reset corners.
module tb_ms_wdt_window;
  localparam int W = 32;
  localparam int P = 8;
  localparam int H = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WARN = 2'd2;
  localparam logic [1:0] S_BITE = 2'd3;

  logic         clk = 1'b0;
  logic         rst, en, kick, irq_clr;
  logic [W-1:0] load, window, count;
  logic [P-1:0] presc;
  logic         irq, early_err, wdt_rst;
  logic [1:0]   state;

  always #5 clk = ~clk;

  ms_wdt_window #(.WIDTH(W), .PRE_W(P), .RST_HOLD(H)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .window(window),
    .presc(presc), .kick(kick), .irq_clr(irq_clr), .count(count),
    .irq(irq), .early_err(early_err), .wdt_rst(wdt_rst), .state(state)
  );

  typedef struct {
    logic         rst, en, kick, clr;
    logic [W-1:0] ld, win;
    logic [P-1:0] ps;
    logic [1:0]   st;
    logic [W-1:0] cnt;
    logic         irq, early, wrst;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic e, input logic k, input logic c,
                              input logic [W-1:0] ld, input logic [W-1:0] wn, input logic [P-1:0] ps,
                              input logic [1:0] st, input logic [W-1:0] cn,
                              input logic i, input logic er, input logic wr);
    tbl.push_back('{r, e, k, c, ld, wn, ps, st, cn, i, er, wr});
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; kick = 1'b0; irq_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_cnt(input logic [W-1:0] v, input int budget, input string name);
    int k = 0;
    while (count !== v && k < budget) begin
      step();
      k++;
    end
    chk(name, count, v);
  endtask

  task automatic wait_state(input logic [1:0] v, input int budget, input string name);
    int k = 0;
    while (state !== v && k < budget) begin
      step();
      k++;
    end
    chk(name, {30'd0, state}, {30'd0, v});
  endtask

  initial begin
    int nhigh;
    rst = 1'b1; en = 1'b0; kick = 1'b0; irq_clr = 1'b0;
    load = 32'd0; window = 32'd0; presc = 8'd0;

    // Table: rst en kick clr load win presc | state count irq early wdt_rst
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5, 8'd0, S_IDLE, 32'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5, 8'd0, S_IDLE, 32'd5, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 8'd0, S_RUN,  32'd5, 1'b0, 1'b0, 1'b0);
    for (int k = 4; k >= 0; k--)
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 8'd0, S_RUN, W'(k), 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 8'd0, S_WARN, 32'd5, 1'b1, 1'b0, 1'b0);
    for (int k = 4; k >= 0; k--)
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 8'd0, S_WARN, W'(k), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 8'd0, S_BITE, 32'd0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 8'd0, S_RUN,  32'd5, 1'b0, 1'b0, 1'b0);
    // Early kick (count 5 > window 2), then en dropped mid-bite
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'd5, 32'd2, 8'd0, S_BITE, 32'd5, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd2, 8'd0, S_BITE, 32'd5, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd2, 8'd0, S_BITE, 32'd5, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd2, 8'd0, S_BITE, 32'd5, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd2, 8'd0, S_IDLE, 32'd5, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 32'd2, 8'd0, S_IDLE, 32'd5, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd2, 8'd0, S_IDLE, 32'd5, 1'b0, 1'b0, 1'b0);
    // load=0: timeout on the first tick; irq_clr loses to nothing here, bite clears irq
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0, S_RUN,  32'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0, S_WARN, 32'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 8'd0, S_BITE, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 8'd0, S_BITE, 32'd0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 8'd0, S_RUN,  32'd7, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'd7, 32'd0, 8'd0, S_IDLE, 32'd7, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; en = tbl[i].en; kick = tbl[i].kick; irq_clr = tbl[i].clr;
      load = tbl[i].ld; window = tbl[i].win; presc = tbl[i].ps;
      step();
      chk($sformatf("v%0d.state", i), {30'd0, state}, {30'd0, tbl[i].st});
      chk($sformatf("v%0d.count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d.irq", i), {31'd0, irq}, {31'd0, tbl[i].irq});
      chk($sformatf("v%0d.early", i), {31'd0, early_err}, {31'd0, tbl[i].early});
      chk($sformatf("v%0d.wdt_rst", i), {31'd0, wdt_rst}, {31'd0, tbl[i].wrst});
    end
    kick = 1'b0; irq_clr = 1'b0;

    // Prescaler: presc=3, load=2 -> irq exactly 12 clocks after RUN entry
    do_reset();
    presc = 8'd3; load = 32'd2; window = 32'd2; en = 1'b1;
    step();
    chk("presc.run_entry", {30'd0, state}, {30'd0, S_RUN});
    for (int t = 1; t <= 12; t++) begin
      step();
      if (t == 3)  chk("presc.t3_count", count, 32'd2);
      if (t == 4)  chk("presc.t4_count", count, 32'd1);
      if (t == 8)  chk("presc.t8_count", count, 32'd0);
      if (t == 11) chk("presc.t11_irq", {31'd0, irq}, 32'd0);
      if (t == 12) chk("presc.t12_irq", {31'd0, irq}, 32'd1);
    end
    chk("presc.warn", {30'd0, state}, {30'd0, S_WARN});

    // Early kick at count=50 with window=10
    do_reset();
    presc = 8'd0; load = 32'd100; window = 32'd10; en = 1'b1;
    step();
    wait_cnt(32'd50, 200, "early.reach50");
    kick = 1'b1;
    step();
    kick = 1'b0;
    chk("early.state", {30'd0, state}, {30'd0, S_BITE});
    chk("early.flag", {31'd0, early_err}, 32'd1);
    chk("early.count_frozen", count, 32'd50);
    nhigh = wdt_rst ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (wdt_rst) nhigh++;
    end
    chk("early.pulse_len", nhigh, 32'd4);
    chk("early.after_state", {30'd0, state}, {30'd0, S_RUN});

    // Valid kick at count=7 while in WARN
    do_reset();
    presc = 8'd0; load = 32'd100; window = 32'd10; en = 1'b1;
    step();
    wait_state(S_WARN, 300, "warnkick.reach_warn");
    chk("warnkick.irq_set", {31'd0, irq}, 32'd1);
    wait_cnt(32'd7, 200, "warnkick.reach7");
    kick = 1'b1;
    step();
    kick = 1'b0;
    chk("warnkick.irq", {31'd0, irq}, 32'd0);
    chk("warnkick.count", count, 32'd100);
    chk("warnkick.state", {30'd0, state}, {30'd0, S_RUN});
    chk("warnkick.wdt_rst", {31'd0, wdt_rst}, 32'd0);

    // Kick coincident with tick at count=0, window=0
    do_reset();
    presc = 8'd0; load = 32'd3; window = 32'd0; en = 1'b1;
    step();
    wait_cnt(32'd0, 20, "zerokick.reach0");
    kick = 1'b1;
    step();
    kick = 1'b0;
    chk("zerokick.state", {30'd0, state}, {30'd0, S_RUN});
    chk("zerokick.count", count, 32'd3);
    chk("zerokick.irq", {31'd0, irq}, 32'd0);

    // rst during BITE
    do_reset();
    presc = 8'd0; load = 32'd2; window = 32'd0; en = 1'b1;
    step();
    kick = 1'b1;
    step();
    kick = 1'b0;
    chk("rstbite.in_bite", {30'd0, state}, {30'd0, S_BITE});
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstbite.state", {30'd0, state}, {30'd0, S_IDLE});
    chk("rstbite.count", count, 32'd0);
    chk("rstbite.wdt_rst", {31'd0, wdt_rst}, 32'd0);
    chk("rstbite.flags", {30'd0, irq, early_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
